muldiv_unit: RTL and testbench

- Iterative RV64M multiply/divide unit instantiated inside the execute stage, directly upstream of the memory stage.
- Accepts one operation per handshake. Holds its result until execute can hand it on; execute writes that result into the alu_out field of execute_data_t.
- Its busy signal feeds execute's stall. Execute therefore cannot advance a mul/div instruction to memory until the result is handed over.

---
 rtl/muldiv_pkg.sv | 53 +++++
 rtl/muldiv_divider.sv | 65 ++++++
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared pipe types for the RV64M multiply/divide unit.
// Ops, FSM states, the execute decode control slice and small decode helpers.
package muldiv_pkg;

  localparam int unsigned MULDIV_XLEN = 64;

  typedef enum logic [3:0] {
    MD_MUL   = 4'd0,
    MD_MULW  = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_REM   = 4'd4,
    MD_REMU  = 4'd5,
    MD_DIVW  = 4'd6,
    MD_DIVUW = 4'd7,
    MD_REMW  = 4'd8,
    MD_REMUW = 4'd9
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // Fields execute's decode control struct carries for mul/div instructions
  typedef struct packed {
    logic       mul_div;
    muldiv_op_t muldiv_op;
  } muldiv_ctrl_t;

  function automatic logic is_word_op(input muldiv_op_t op);
    return op inside {MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
  endfunction

  function automatic logic is_signed_div(input muldiv_op_t op);
    return op inside {MD_DIV, MD_REM, MD_DIVW, MD_REMW};
  endfunction

  function automatic logic is_rem_op(input muldiv_op_t op);
    return op inside {MD_REM, MD_REMU, MD_REMW, MD_REMUW};
  endfunction

  function automatic logic is_mul_op(input muldiv_op_t op);
    return op inside {MD_MUL, MD_MULW};
  endfunction

  function automatic logic [MULDIV_XLEN-1:0] sext_word(input logic [MULDIV_XLEN-1:0] v,
                                                       input logic word);
    return word ? {{(MULDIV_XLEN/2){v[MULDIV_XLEN/2-1]}}, v[MULDIV_XLEN/2-1:0]} : v;
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring unsigned divider on operand magnitudes, one quotient bit per cycle.
// quotient_c/remainder_c are this cycle's step result; done_c flags the final step.
module muldiv_divider
  import muldiv_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   word,
  input  logic [MULDIV_XLEN-1:0] dividend,
  input  logic [MULDIV_XLEN-1:0] divisor,
  output logic [MULDIV_XLEN-1:0] quotient_c,
  output logic [MULDIV_XLEN-1:0] remainder_c,
  output logic                   done_c
);

  localparam int unsigned W     = MULDIV_XLEN;
  localparam int unsigned HW    = W / 2;
  localparam int unsigned CNT_W = $clog2(W);

  logic [W-1:0]     rem_q;
  logic [W-1:0]     quo_q;
  logic [W-1:0]     dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;
  logic [W:0]       shifted;
  logic [W:0]       diff;
  logic             fits;

  // One restoring step; bit W of diff is the borrow of the trial subtract
  always_comb begin
    shifted     = {rem_q, quo_q[W-1]};
    diff        = shifted - {1'b0, dsr_q};
    fits        = ~diff[W];
    remainder_c = fits ? diff[W-1:0] : shifted[W-1:0];
    quotient_c  = {quo_q[W-2:0], fits};
    done_c      = active_q & (cnt_q == '0);
  end

  // Word ops park the 32-bit dividend in the top half so 32 steps consume it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (abort) begin
      active_q <= 1'b0;
    end else if (start) begin
      rem_q    <= '0;
      quo_q    <= word ? {dividend[HW-1:0], {HW{1'b0}}} : dividend;
      dsr_q    <= divisor;
      cnt_q    <= word ? CNT_W'(HW - 1) : CNT_W'(W - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= remainder_c;
      quo_q <= quotient_c;
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the execute stage.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle one.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned MUL_CYCLES = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int unsigned W  = MULDIV_XLEN;
  localparam int unsigned HW = W / 2;
  localparam logic [W-1:0] MIN_D = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MIN_W = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

  muldiv_state_t state;
  logic          word_q, is_rem_q, neg_q_q, neg_r_q;

  muldiv_op_t    op;
  logic          word, sgn, is_mul, is_rem;
  logic [W-1:0]  a_ext, b_ext, a_mag, b_mag;
  logic          a_neg, b_neg, div_zero, ovf, special, accept;
  logic [W-1:0]  special_res;

  logic          div_start, div_done_c;
  logic [W-1:0]  div_quo_c, div_rem_c, div_res;

  // Operand preparation and accept-time special-case detection
  always_comb begin
    op     = muldiv_op_t'(in_op);
    word   = is_word_op(op);
    sgn    = is_signed_div(op);
    is_mul = is_mul_op(op);
    is_rem = is_rem_op(op);
    a_ext  = in_a;
    b_ext  = in_b;
    if (word) begin
      a_ext = {{HW{sgn & in_a[HW-1]}}, in_a[HW-1:0]};
      b_ext = {{HW{sgn & in_b[HW-1]}}, in_b[HW-1:0]};
    end
    a_neg    = sgn & a_ext[W-1];
    b_neg    = sgn & b_ext[W-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = sgn & (a_ext == (word ? MIN_W : MIN_D)) & (&b_ext);
    special  = ~is_mul & (div_zero | ovf);
    if (div_zero) special_res = sext_word(is_rem ? a_ext : '1, word);
    else          special_res = sext_word(is_rem ? '0 : a_ext, word);
    accept    = (state == IDLE) & in_valid & ~flush;
    div_start = accept & ~is_mul & ~special;
  end

  assign div_res = is_rem_q ? (neg_r_q ? -div_rem_c : div_rem_c)
                            : (neg_q_q ? -div_quo_c : div_quo_c);

  assign busy = (state == BUSY) | ((state == DONE) & ~out_ready);

  muldiv_divider u_divider (
    .clk        (clk),
    .resetn     (resetn),
    .start      (div_start),
    .abort      (flush),
    .word       (word),
    .dividend   (a_mag),
    .divisor    (b_mag),
    .quotient_c (div_quo_c),
    .remainder_c(div_rem_c),
    .done_c     (div_done_c)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [W-1:0] fast_prod;

  assign fast_prod = a_ext * b_ext;
`else
  localparam int unsigned MUL_CNT_W = $clog2(MUL_CYCLES) + 1;

  logic                 is_mul_q, mul_last;
  logic [W-1:0]         mul_acc, mul_a, mul_b, mul_acc_next;
  logic [MUL_CNT_W-1:0] mul_cnt;

  assign mul_acc_next = mul_acc + (mul_b[0] ? mul_a : '0);
  assign mul_last     = is_mul_q & (mul_cnt == '0);

  // Shift-add multiplier; only the low W product bits are ever needed
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_mul_q <= 1'b0;
      mul_acc  <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_cnt  <= '0;
    end else if (accept) begin
      is_mul_q <= is_mul;
      mul_acc  <= '0;
      mul_a    <= a_ext;
      mul_b    <= b_ext;
      mul_cnt  <= word ? MUL_CNT_W'(HW - 1) : MUL_CNT_W'(MUL_CYCLES - 1);
    end else if ((state == BUSY) && is_mul_q) begin
      mul_acc <= mul_acc_next;
      mul_a   <= {mul_a[W-2:0], 1'b0};
      mul_b   <= {1'b0, mul_b[W-1:1]};
      if (mul_cnt != '0) mul_cnt <= mul_cnt - MUL_CNT_W'(1);
    end
  end
`endif

  // Control FSM; flush beats everything, including a pending hand-off
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      word_q     <= 1'b0;
      is_rem_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_q   <= word;
            is_rem_q <= is_rem;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            in_ready <= 1'b0;
            if (special) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= special_res;
`ifdef MULDIV_FAST_MUL_EN
            end else if (is_mul) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= sext_word(fast_prod, word);
`endif
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
`ifndef MULDIV_FAST_MUL_EN
          if (is_mul_q) begin
            if (mul_last) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= sext_word(mul_acc_next, word_q);
            end
          end else
`endif
          if (div_done_c) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_result <= sext_word(div_res, word_q);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, handshake/flush/reset
// sequences and random ops against a plain-arithmetic RV64M reference.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MULW_LAT = 1;
`else
  localparam int MUL_LAT  = 65;
  localparam int MULW_LAT = 33;
`endif
  localparam longint LMIN = 64'sh8000_0000_0000_0000;
  localparam int     IMIN = 32'sh8000_0000;

  logic        clk, resetn, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  in_op;
  logic [63:0] in_a, in_b, out_result;

  int checks   = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference results straight from the RV64M definitions
  function automatic logic [63:0] model(input muldiv_op_t op, input logic [63:0] a,
                                        input logic [63:0] b);
    longint      sa, sb;
    int          sa32, sb32;
    int unsigned ua32, ub32;
    logic [63:0] p;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    p = a * b;
    case (op)
      MD_MUL:   return p;
      MD_MULW:  return sx32(p[31:0]);
      MD_DIV:   if (sb == 0) return '1; else if (sa == LMIN && sb == -1) return a; else return sa / sb;
      MD_DIVU:  if (b == 0) return '1; else return a / b;
      MD_REM:   if (sb == 0) return a; else if (sa == LMIN && sb == -1) return 0; else return sa % sb;
      MD_REMU:  if (b == 0) return a; else return a % b;
      MD_DIVW:  if (sb32 == 0) return '1; else if (sa32 == IMIN && sb32 == -1) return sx32(32'(sa32));
                else return sx32(32'(sa32 / sb32));
      MD_DIVUW: if (ub32 == 0) return '1; else return sx32(32'(ua32 / ub32));
      MD_REMW:  if (sb32 == 0) return sx32(32'(sa32)); else if (sa32 == IMIN && sb32 == -1) return 0;
                else return sx32(32'(sa32 % sb32));
      default:  if (ub32 == 0) return sx32(32'(ua32)); else return sx32(32'(ua32 % ub32));
    endcase
  endfunction

  function automatic int model_lat(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b);
    bit w, s, zero, ov;
    if (op == MD_MUL)  return MUL_LAT;
    if (op == MD_MULW) return MULW_LAT;
    w    = (op == MD_DIVW || op == MD_DIVUW || op == MD_REMW || op == MD_REMUW);
    s    = (op == MD_DIV || op == MD_REM || op == MD_DIVW || op == MD_REMW);
    zero = w ? (b[31:0] == 32'h0) : (b == 64'h0);
    ov   = s && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                   : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (zero || ov) return 1;
    return w ? 33 : 65;
  endfunction

  // Issue one op from a negedge in IDLE; returns at the negedge after hand-off
  task automatic do_op(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input int exp_lat, input int hold,
                       input bit junk, input string name);
    int lat;
    bit wait_bad, hold_bad;
    chk({name, " in_ready"}, in_ready, 1);
    in_valid = 1; in_op = op; in_a = a; in_b = b; out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = junk; in_op = MD_DIVU; in_a = 64'd9; in_b = 64'd0;
    lat = 1; wait_bad = 0; hold_bad = 0;
    while (!out_valid && lat < 200) begin
      if (!busy || in_ready) wait_bad = 1;
      if (lat >= 4) in_valid = 0;
      @(negedge clk);
      lat++;
    end
    in_valid = 0;
    chk({name, " out_valid"}, out_valid, 1);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " result"}, out_result, exp_res);
    chk({name, " busy_while_busy"}, wait_bad, 0);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (!out_valid || out_result !== exp_res || !busy || in_ready) hold_bad = 1;
        @(negedge clk);
      end
      if (!out_valid || out_result !== exp_res || !busy) hold_bad = 1;
      chk({name, " hold"}, hold_bad, 0);
      out_ready = 1;
      #1;
    end
    chk({name, " busy_at_handoff"}, busy, 0);
    @(negedge clk);
    chk({name, " valid_drops"}, out_valid, 0);
    chk({name, " ready_back"}, in_ready, 1);
  endtask

  typedef struct {
    muldiv_op_t  op;
    logic [63:0] a, b, res;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int          lat;
    bit          seen;
    muldiv_op_t  rop;
    logic [63:0] ra, rb;

    vecs[0]  = '{MD_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[1]  = '{MD_REMW,  64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[2]  = '{MD_DIVW,  64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[3]  = '{MD_DIVU,  64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[4]  = '{MD_REMU,  64'd100, 64'd0, 64'd100, 1};
    vecs[5]  = '{MD_MULW,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MULW_LAT};
    vecs[6]  = '{MD_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[7]  = '{MD_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[8]  = '{MD_DIVUW, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 33};
    vecs[9]  = '{MD_REMW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[10] = '{MD_MUL,   64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, MUL_LAT};
    vecs[11] = '{MD_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 65};

    resetn = 0; flush = 0; in_valid = 0; in_op = MD_MUL; in_a = 0; in_b = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset out_result", out_result, 0);
    resetn = 1;
    @(negedge clk);

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 0,
            vecs[i].lat >= 33, $sformatf("vec%0d", i));

    // Result held while execute stalls, then an immediate back-to-back accept
    do_op(MD_MUL, 64'd3, 64'd5, 64'd15, MUL_LAT, 10, 0, "mul_hold");
    do_op(MD_REMU, 64'd100, 64'd0, 64'd100, 1, 0, 0, "back_to_back");

    // Flush mid-divide: IDLE next cycle, no result ever shows up
    in_valid = 1; in_op = MD_DIV; in_a = 64'd1000; in_b = 64'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; lat = 1;
    while (lat < 20) begin @(negedge clk); lat++; end
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    chk("flush busy", busy, 0);
    seen = 0;
    repeat (70) begin @(negedge clk); if (out_valid) seen = 1; end
    chk("flush no_result", seen, 0);

    // Flush coinciding with a request suppresses the accept
    in_valid = 1; in_op = MD_DIV; in_a = 64'd50; in_b = 64'd7; flush = 1;
    @(negedge clk);
    in_valid = 0; flush = 0;
    chk("flush_accept busy", busy, 0);
    chk("flush_accept in_ready", in_ready, 1);

    // Flush beats a held result even with out_ready high
    in_valid = 1; in_op = MD_DIVU; in_a = 64'd100; in_b = 64'd0; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    chk("flush_done held", out_valid, 1);
    flush = 1; out_ready = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_done out_valid", out_valid, 0);
    chk("flush_done in_ready", in_ready, 1);

    // Reset mid-divide returns outputs to reset values at once
    do_op(MD_DIV, 64'd1000, 64'd7, 64'd142, 65, 0, 0, "pre_reset");
    in_valid = 1; in_op = MD_DIV; in_a = 64'd12345; in_b = 64'd7;
    @(negedge clk);
    in_valid = 0; lat = 1;
    while (lat < 30) begin @(negedge clk); lat++; end
    resetn = 0;
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset in_ready", in_ready, 1);
    chk("midreset busy", busy, 0);
    chk("midreset out_result", out_result, 0);
    @(negedge clk);
    resetn = 1;
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      rop = muldiv_op_t'($urandom_range(0, 9));
      case ($urandom_range(0, 5))
        0: ra = {$urandom, $urandom};
        1: ra = 64'($urandom_range(0, 50));
        2: ra = -64'($urandom_range(1, 50));
        3: ra = 64'h8000_0000_0000_0000;
        4: ra = 64'hFFFF_FFFF_8000_0000;
        default: ra = {32'h0, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0: rb = {$urandom, $urandom};
        1: rb = 64'($urandom_range(0, 9));
        2: rb = 64'hFFFF_FFFF_FFFF_FFFF;
        3: rb = {$urandom, 32'h0};
        4: rb = -64'($urandom_range(1, 9));
        default: rb = {32'h0, $urandom};
      endcase
      lat = model_lat(rop, ra, rb);
      do_op(rop, ra, rb, model(rop, ra, rb), lat, $urandom_range(0, 2), lat >= 33,
            $sformatf("rand%0d op%0d", n, rop));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
